// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Define UART_ARB_PACKET_LOCK_EN to keep multi-byte packets (terminated by req_last_i) from interleaving.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset_n_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 uart_wr_o,
    output logic [7:0]           uart_data_o,
    input  logic                 uart_busy_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state_r;
    logic [PTR_W-1:0]   ptr_r;
    logic [NUM_REQ-1:0] grant_r;
    logic [7:0]         data_r;
    logic               wr_r;
    logic               busy_r;

    logic               lock_held_s;
    logic [NUM_REQ-1:0] eligible_s;
    logic [NUM_REQ-1:0] win_onehot_s;
    logic [PTR_W-1:0]   win_idx_s;
    logic [PTR_W-1:0]   scan_idx_s;
    logic               scan_hit_s;
    logic               win_found_s;
    logic               accept_s;
    logic [7:0]         win_data_s;

`ifdef UART_ARB_PACKET_LOCK_EN
    logic lock_r;

    assign lock_held_s = lock_r;

    // Packet lock: set by a non-final byte, released by the final byte of the packet.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lock_r <= 1'b0;
        end else if (accept_s) begin
            lock_r <= ~req_last_i[win_idx_s];
        end else begin
            lock_r <= lock_r;
        end
    end
`else
    logic unused_last_s;

    assign unused_last_s = ^req_last_i;
    assign lock_held_s   = 1'b0;
`endif

    // While locked only the current owner may compete.
    assign eligible_s = req_valid_i & (lock_held_s ? grant_r : {NUM_REQ{1'b1}});

    // Round-robin scan starting just after the last winner.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = ptr_r;
        scan_idx_s  = ptr_r;
        scan_hit_s  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_idx_s  = PTR_W'((int'(ptr_r) + i) % NUM_REQ);
            scan_hit_s  = ~win_found_s & eligible_s[scan_idx_s];
            win_idx_s   = scan_hit_s ? scan_idx_s : win_idx_s;
            win_found_s = win_found_s | scan_hit_s;
        end
    end

    assign accept_s     = (state_r == IDLE) & win_found_s & ~uart_busy_i;
    assign win_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
    assign win_data_s   = req_data_i[{win_idx_s, 3'b000} +: 8];
    assign req_ready_o  = accept_s ? win_onehot_s : {NUM_REQ{1'b0}};

    // Transfer sequencer: accept, one-cycle write strobe, busy blind cycle, wait for drain.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            ptr_r   <= PTR_W'(NUM_REQ - 1);
            grant_r <= {NUM_REQ{1'b0}};
            data_r  <= 8'h00;
            wr_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= ISSUE;
                        ptr_r   <= win_idx_s;
                        grant_r <= win_onehot_s;
                        data_r  <= win_data_s;
                        wr_r    <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                ISSUE: begin
                    wr_r    <= 1'b0;
                    state_r <= HOLD;
                end
                HOLD: begin
                    state_r <= DRAIN;
                end
                DRAIN: begin
                    if (!uart_busy_i) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        if (!lock_held_s) begin
                            grant_r <= {NUM_REQ{1'b0}};
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    wr_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    grant_r <= {NUM_REQ{1'b0}};
                end
            endcase
        end
    end

    assign uart_wr_o   = wr_r;
    assign uart_data_o = data_r;
    assign grant_o     = grant_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised self-checking bench for uart_tx_arbiter against a cycle-level behavioural model.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n_i;
    logic [N-1:0]   req_valid_i;
    logic [8*N-1:0] req_data_i;
    logic [N-1:0]   req_last_i;
    logic [N-1:0]   req_ready_o;
    logic           uart_wr_o;
    logic [7:0]     uart_data_o;
    logic           uart_busy_i;
    logic [N-1:0]   grant_o;
    logic           busy_o;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .reset_n_i   (reset_n_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .uart_wr_o   (uart_wr_o),
        .uart_data_o (uart_data_o),
        .uart_busy_i (uart_busy_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    int checks = 0;
    int errors = 0;

    // producers: pending entry per requester plus a backlog queue of {last, data}
    logic [N-1:0] pv;
    logic [N-1:0] pl;
    logic [7:0]   pdat [N];
    logic [8:0]   q [N][$];
    bit           keep_valid;
    bit           rand_mode;

    // UART busy model
    int  bcnt;
    int  busy_len;
    bit  force_busy;

    // reference model
    int         m_ptr;
    int         m_grant;
    int         m_phase;   // 0 idle, 1 strobe cycle, 2 blind cycle, 3+ draining
    logic [7:0] m_data;
    bit         m_lock;

    // observation log
    logic [7:0] log_data [$];
    int         log_req [$];
    int         rdy_cnt;
    logic [N-1:0] rdy_last;
    int         busy_cyc;
    int         wr_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_winner();
        if (m_phase != 0 || uart_busy_i) return -1;
        for (int i = 1; i <= N; i++) begin
            int r;
            r = (m_ptr + i) % N;
            if (req_valid_i[r] && (!m_lock || r == m_grant)) return r;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = N - 1;
        m_grant = -1;
        m_phase = 0;
        m_data  = 8'h00;
        m_lock  = 1'b0;
    endtask

    task automatic drive();
        req_valid_i = pv;
        req_last_i  = pl;
        for (int r = 0; r < N; r++) req_data_i[8*r +: 8] = pdat[r];
        uart_busy_i = force_busy || (bcnt > 0);
    endtask

    // One clock cycle: refresh producers, compare every output against the model, advance the model.
    task automatic step();
        int   w;
        logic wr_seen;
        @(negedge clk);
        for (int r = 0; r < N; r++) begin
            if (rand_mode && q[r].size() == 0 && $urandom_range(0, 3) == 0)
                q[r].push_back({($urandom_range(0, 2) == 0), 8'($urandom)});
            if (rand_mode && pv[r] && $urandom_range(0, 40) == 0)
                pv[r] = 1'b0;
            else if (!pv[r] && q[r].size() != 0) begin
                logic [8:0] e;
                e = q[r].pop_front();
                pv[r] = 1'b1;
                pl[r] = e[8];
                pdat[r] = e[7:0];
            end
        end
        if (rand_mode && bcnt == 0 && $urandom_range(0, 20) == 0) bcnt = $urandom_range(1, 4);
        drive();
        #1;
        w = model_winner();
        check("ready", req_ready_o, (w < 0) ? 0 : (1 << w));
        check("wr", uart_wr_o, (m_phase == 1) ? 1 : 0);
        check("data", uart_data_o, m_data);
        check("grant", grant_o, (m_grant < 0) ? 0 : (1 << m_grant));
        check("busy", busy_o, (m_phase != 0) ? 1 : 0);
        if (req_ready_o != '0) begin rdy_cnt++; rdy_last = req_ready_o; end
        if (busy_o) busy_cyc++;
        wr_seen = uart_wr_o;
        if (uart_wr_o) begin
            wr_cnt++;
            log_data.push_back(uart_data_o);
            log_req.push_back(m_grant);
        end
        @(posedge clk);
        if (wr_seen) bcnt = (busy_len > 0) ? busy_len : $urandom_range(1, 12);
        else if (bcnt > 0) bcnt--;
        if (w >= 0) begin
            m_phase = 1;
            m_data  = pdat[w];
            m_ptr   = w;
            m_grant = w;
`ifdef UART_ARB_PACKET_LOCK_EN
            m_lock  = !pl[w];
`endif
            if (!keep_valid) pv[w] = 1'b0;
        end else if (m_phase == 1 || m_phase == 2) begin
            m_phase++;
        end else if (m_phase >= 3 && !uart_busy_i) begin
            m_phase = 0;
            if (!m_lock) m_grant = -1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n_i = 1'b0;
        pv = '0;
        pl = '0;
        for (int r = 0; r < N; r++) begin pdat[r] = 8'h00; q[r].delete(); end
        bcnt = 0;
        drive();
        #1;
        check("rst_ready", req_ready_o, 0);
        check("rst_wr", uart_wr_o, 0);
        check("rst_data", uart_data_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_busy", busy_o, 0);
        @(negedge clk);
        reset_n_i = 1'b1;
        model_reset();
        log_data.delete();
        log_req.delete();
        rdy_cnt = 0; busy_cyc = 0; wr_cnt = 0; rdy_last = '0;
    endtask

    task automatic run_until(input int n, input int max_cyc, input string name);
        int c;
        c = 0;
        while (log_data.size() < n && c < max_cyc) begin step(); c++; end
        check({name, "_timeout"}, (log_data.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic check_seq(input string name, input logic [7:0] d [], input int rq []);
        for (int i = 0; i < d.size(); i++) begin
            check($sformatf("%s_data%0d", name, i), (i < log_data.size()) ? log_data[i] : 32'hdead, d[i]);
            check($sformatf("%s_req%0d", name, i), (i < log_req.size()) ? log_req[i] : -1, rq[i]);
        end
    endtask

    initial begin
        logic [7:0] ed [];
        int         er [];
        reset_n_i = 1'b1;
        keep_valid = 1'b0; rand_mode = 1'b0; force_busy = 1'b0;
        busy_len = 10; bcnt = 0;
        model_reset();
        pv = '0; pl = '0;
        for (int r = 0; r < N; r++) pdat[r] = 8'h00;
        drive();

        // single byte from requester 2
        do_reset();
        q[2].push_back({1'b1, 8'h41});
        run_until(1, 20, "single");
        repeat (20) step();
        ed = new[1]; ed[0] = 8'h41;
        er = new[1]; er[0] = 2;
        check_seq("single", ed, er);
        check("single_ready_cnt", rdy_cnt, 1);
        check("single_ready_val", rdy_last, 4'b0100);
        check("single_wr_cnt", wr_cnt, 1);
        check("single_busy_cyc", busy_cyc, 12);

        // round robin with everyone continuously valid
        do_reset();
        busy_len = 3;
        keep_valid = 1'b1;
        for (int r = 0; r < N; r++) q[r].push_back({1'b1, 8'(8'h10 + r)});
        run_until(5, 200, "rr");
        keep_valid = 1'b0;
        ed = new[5]; er = new[5];
        for (int i = 0; i < 5; i++) begin ed[i] = 8'(8'h10 + (i % N)); er[i] = i % N; end
        check_seq("rr", ed, er);

        // UART busy across reset release
        force_busy = 1'b1;
        do_reset();
        q[0].push_back({1'b1, 8'h55});
        repeat (20) step();
        check("pbusy_no_ready", rdy_cnt, 0);
        force_busy = 1'b0;
        step();
        check("pbusy_first_accept", rdy_last, 4'b0001);

        // packet of three from requester 1 competing with requester 0
        do_reset();
        busy_len = 2;
        q[1].push_back({1'b0, 8'hA1});
        q[1].push_back({1'b0, 8'hA2});
        q[1].push_back({1'b1, 8'hA3});
        step();
        q[0].push_back({1'b1, 8'hB0});
        q[0].push_back({1'b1, 8'hB1});
        run_until(5, 200, "pkt");
        ed = new[5]; er = new[5];
`ifdef UART_ARB_PACKET_LOCK_EN
        ed[0] = 8'hA1; ed[1] = 8'hA2; ed[2] = 8'hA3; ed[3] = 8'hB0; ed[4] = 8'hB1;
        er[0] = 1; er[1] = 1; er[2] = 1; er[3] = 0; er[4] = 0;
`else
        ed[0] = 8'hA1; ed[1] = 8'hB0; ed[2] = 8'hA2; ed[3] = 8'hB1; ed[4] = 8'hA3;
        er[0] = 1; er[1] = 0; er[2] = 1; er[3] = 0; er[4] = 1;
`endif
        check_seq("pkt", ed, er);

        // reset while draining, then fresh arbitration from requester 0
        do_reset();
        busy_len = 10;
        q[1].push_back({1'b0, 8'h77});
        for (int c = 0; c < 12 && m_phase < 3; c++) step();
        check("mid_in_drain", (m_phase >= 3) ? 1 : 0, 1);
        do_reset();
        q[3].push_back({1'b1, 8'h03});
        q[0].push_back({1'b1, 8'h01});
        run_until(2, 100, "mid");
        repeat (15) step();
        ed = new[2]; er = new[2];
        ed[0] = 8'h01; ed[1] = 8'h03;
        er[0] = 0; er[1] = 3;
        check_seq("mid", ed, er);
        check("mid_no_reissue", log_data.size(), 2);

        // long randomised run
        do_reset();
        busy_len = 0;
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        check("rand_traffic", (log_data.size() > 50) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
